// File: rtl/mix_columns_iter_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES GF(2^8) helpers and constants for the iterative MixColumns engine.
//   AES_POLY_LO    : low byte of the reduction polynomial 0x11B
//   COL_W, STATE_W : column and state widths
//   mixcol_state_t : engine FSM states
//   xtime          : multiply by 2 in GF(2^8)
//   gf_mul_const   : multiply by a 4-bit constant using at most 3 xtime stages
// Optional feature macro used by the files importing this package:
//   MIX_COLUMNS_INV_EN
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AES_POLY_LO = 8'h1B;
    localparam int         COL_W       = 32;
    localparam int         STATE_W     = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mixcol_state_t;

    // Shift left and fold the carried-out bit back in with the polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (AES_POLY_LO & {8{b[7]}});
    endfunction

    // Constant coefficients are at most 4 bits (0x0E), so x2/x4/x8 cover them;
    // with a literal coefficient the unused partial products are pruned.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

endpackage

// File: rtl/mix_columns_iter_if.sv
// -----------------------------------------------------------------------------
// mix_columns_iter_if
// Input and output valid/ready handshakes of the MixColumns engine.
//   in_valid/in_ready/in_state    : state offered by upstream (ShiftRows)
//   out_valid/out_ready/out_state : result offered to downstream (AddRoundKey)
//   inv                           : inverse-transform select, only when
//                                   MIX_COLUMNS_INV_EN is defined
// Modports: master = traffic source/sink side, slave = engine side.
// -----------------------------------------------------------------------------
interface mix_columns_iter_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] out_state;
`ifdef MIX_COLUMNS_INV_EN
    logic               inv;
`endif

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
`ifdef MIX_COLUMNS_INV_EN
        , output inv
`endif
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
`ifdef MIX_COLUMNS_INV_EN
        , input inv
`endif
    );

endinterface

// File: rtl/mix_column_word.sv
// -----------------------------------------------------------------------------
// mix_column_word
// Combinational single-column MixColumns transform.
//   i_col : 32-bit input column, byte 0 in bits [31:24]
//   i_inv : present only with MIX_COLUMNS_INV_EN; 1 selects InvMixColumns
//   o_col : 32-bit transformed column, same byte layout
// Without MIX_COLUMNS_INV_EN only the forward coefficients are built.
// -----------------------------------------------------------------------------
module mix_column_word
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
`ifdef MIX_COLUMNS_INV_EN
    input  logic             i_inv,
`endif
    output logic [COL_W-1:0] o_col
);

    // First coefficient row, one nibble per byte position; later output rows
    // use the same row rotated right by the output index.
    localparam logic [15:0] FWD_ROW = 16'h2311;
`ifdef MIX_COLUMNS_INV_EN
    localparam logic [15:0] INV_ROW = 16'hEBD9;
`endif

    function automatic logic [COL_W-1:0] mix_with(input logic [COL_W-1:0] col,
                                                  input logic [15:0]      row);
        logic [7:0]       a [4];
        logic [7:0]       acc;
        logic [COL_W-1:0] res;
        int               k;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            a[j] = col[31-8*j -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) begin
                k   = (j - i + 4) % 4;
                acc = acc ^ gf_mul_const(a[j], row[15-4*k -: 4]);
            end
            res[31-8*i -: 8] = acc;
        end
        return res;
    endfunction

    logic [COL_W-1:0] w_fwd;
`ifdef MIX_COLUMNS_INV_EN
    logic [COL_W-1:0] w_inv;
`endif

    always_comb begin
        w_fwd = mix_with(i_col, FWD_ROW);
`ifdef MIX_COLUMNS_INV_EN
        w_inv = mix_with(i_col, INV_ROW);
        o_col = i_inv ? w_inv : w_fwd;
`else
        o_col = w_fwd;
`endif
    end

endmodule

// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
// Iterative AES MixColumns engine: one column per clock through a single
// shared mix_column_word unit, 4 cycles from acceptance to result.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mix_columns_iter_if.slave (input/output valid/ready handshakes)
// Optional feature macro: MIX_COLUMNS_INV_EN adds bus.inv, latched at
// acceptance, selecting InvMixColumns for that state.
// -----------------------------------------------------------------------------
module mix_columns_iter
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mix_columns_iter_if.slave bus
);

    mixcol_state_t      r_fsm;
    mixcol_state_t      w_fsm_next;
    logic [STATE_W-1:0] r_data;
    logic [1:0]         r_col;
    logic [COL_W-1:0]   w_col_in;
    logic [COL_W-1:0]   w_col_out;
`ifdef MIX_COLUMNS_INV_EN
    logic               r_inv;
`endif

    // Result is a direct view of the working register, so it stays stable
    // for as long as DONE is held by backpressure.
    assign bus.out_state = r_data;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next-state and handshake outputs; in_ready only in IDLE so an output
    // handshake and a new acceptance never share a cycle.
    always_comb begin
        w_fsm_next    = r_fsm;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_fsm)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_fsm_next = BUSY;
                end
            end
            BUSY: begin
                if (r_col == 2'd3) begin
                    w_fsm_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_fsm_next = IDLE;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    // Select the column currently being transformed.
    always_comb begin
        w_col_in = r_data[127:96];
        case (r_col)
            2'd0: w_col_in = r_data[127:96];
            2'd1: w_col_in = r_data[95:64];
            2'd2: w_col_in = r_data[63:32];
            2'd3: w_col_in = r_data[31:0];
            default: w_col_in = r_data[127:96];
        endcase
    end

    mix_column_word u_mix (
        .i_col (w_col_in),
`ifdef MIX_COLUMNS_INV_EN
        .i_inv (r_inv),
`endif
        .o_col (w_col_out)
    );

    // Datapath: capture on acceptance, then overwrite one column per BUSY
    // cycle. The counter wraps to 0 naturally after column 3.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_col  <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
            r_inv  <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_data <= bus.in_state;
                        r_col  <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
                        r_inv  <= bus.inv;
`endif
                    end
                end
                BUSY: begin
                    case (r_col)
                        2'd0: r_data[127:96] <= w_col_out;
                        2'd1: r_data[95:64]  <= w_col_out;
                        2'd2: r_data[63:32]  <= w_col_out;
                        2'd3: r_data[31:0]   <= w_col_out;
                        default: r_data[127:96] <= w_col_out;
                    endcase
                    r_col <= r_col + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_iter
// Scoreboard testbench for mix_columns_iter with directed vectors. Inverse
// vectors are included when MIX_COLUMNS_INV_EN is defined.
// -----------------------------------------------------------------------------
module tb_mix_columns_iter;

    logic clk;
    logic rst_n;

    mix_columns_iter_if bus ();

    mix_columns_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] BP_IN    = 128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff;
    localparam logic [127:0] BP_OUT   = 128'hc6c6c6c6_d5d5d7d6_00000000_ffffffff;

    logic [127:0] expQ [$];
    int           acceptLog [$];
    int           outLog [$];
    int           edgeCount = 0;
    int           lastAccept = 0;
    bit           prevOutValid = 0;
    int           checks = 0;
    int           fails = 0;
`ifdef MIX_COLUMNS_INV_EN
    logic         invSel = 1'b0;
`endif

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to timestamp handshakes.
    always @(posedge clk) begin
        edgeCount++;
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offer a state and push its expected result; returns #1 after the
    // accepting edge. holdValid keeps in_valid asserted for a following call.
    task automatic applyStimulus(input logic [127:0] vec, input logic [127:0] exp,
                                 input bit holdValid);
        int waitCycles;
        bit accepted;
        waitCycles = 0;
        accepted   = 1'b0;
        expQ.push_back(exp);
        bus.in_state = vec;
        bus.in_valid = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
        bus.inv = invSel;
`endif
        while (!accepted && waitCycles < 50) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        checkOutput("input accepted", {127'd0, accepted}, 128'd1);
        if (!holdValid) begin
            bus.in_valid = 1'b0;
        end
    endtask

    // Wait, bounded, until every expected result has been seen.
    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("scoreboard drained", expQ.size(), 128'd0);
    endtask

    // Monitor: logs acceptances, checks latency on each out_valid rise and
    // compares each output handshake against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                lastAccept = edgeCount + 1;
                acceptLog.push_back(lastAccept);
            end
            if (bus.out_valid && !prevOutValid) begin
                checkOutput("latency", edgeCount - lastAccept, 128'd4);
            end
            if (bus.out_valid && bus.out_ready) begin
                outLog.push_back(edgeCount + 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected output queue depth", expQ.size(), 128'd1);
                end else begin
                    checkOutput("out_state", bus.out_state, expQ.pop_front());
                end
            end
            prevOutValid = bus.out_valid;
        end else begin
            prevOutValid = 1'b0;
        end
    end

    // Directed test sequence.
    initial begin
        int idx;
        int oidx;
        int n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;
`ifdef MIX_COLUMNS_INV_EN
        bus.inv       = 1'b0;
`endif

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", {127'd0, bus.in_ready}, 128'd1);
        checkOutput("reset out_valid", {127'd0, bus.out_valid}, 128'd0);
        checkOutput("reset out_state", bus.out_state, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIPS-197 forward vector
        $display("[TB] forward vector");
        bus.out_ready = 1'b1;
        applyStimulus(FIPS_IN, FIPS_OUT, 1'b0);
        waitDrain();

        // Backpressure
        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(BP_IN, BP_OUT, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
        checkOutput("bp out_valid", {127'd0, bus.out_valid}, 128'd1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp held out_state", bus.out_state, BP_OUT);
            checkOutput("bp held in_ready", {127'd0, bus.in_ready}, 128'd0);
            checkOutput("bp held out_valid", {127'd0, bus.out_valid}, 128'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp out_valid dropped", {127'd0, bus.out_valid}, 128'd0);
        checkOutput("bp in_ready back", {127'd0, bus.in_ready}, 128'd1);
        checkOutput("bp scoreboard empty", expQ.size(), 128'd0);

        // Reset in the middle of BUSY
        $display("[TB] reset mid-operation");
        bus.out_ready = 1'b1;
        applyStimulus(FIPS_IN, FIPS_OUT, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        @(negedge clk);
        checkOutput("mid-reset out_valid", {127'd0, bus.out_valid}, 128'd0);
        checkOutput("mid-reset out_state", bus.out_state, 128'd0);
        checkOutput("mid-reset in_ready", {127'd0, bus.in_ready}, 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(BP_IN, BP_OUT, 1'b0);
        waitDrain();

        // Back-to-back with in_valid held high
        $display("[TB] back-to-back");
        idx  = acceptLog.size();
        oidx = outLog.size();
        applyStimulus(FIPS_IN, FIPS_OUT, 1'b1);
        applyStimulus(BP_IN, BP_OUT, 1'b0);
        waitDrain();
        checkOutput("b2b accept count", acceptLog.size() - idx, 128'd2);
        if (acceptLog.size() >= idx + 2 && outLog.size() >= oidx + 1) begin
            checkOutput("b2b accept spacing", acceptLog[idx+1] - acceptLog[idx], 128'd6);
            checkOutput("b2b accept after output", acceptLog[idx+1] - outLog[oidx], 128'd1);
        end

`ifdef MIX_COLUMNS_INV_EN
        // Inverse direction, then forward again on the same engine
        $display("[TB] inverse vector");
        invSel = 1'b1;
        applyStimulus(FIPS_OUT, FIPS_IN, 1'b0);
        waitDrain();
        invSel = 1'b0;
        applyStimulus(FIPS_IN, FIPS_OUT, 1'b0);
        waitDrain();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mix_columns_iter.md
# mix_columns_iter

Iterative AES MixColumns engine for the encryption datapath: the forward counterpart of the existing inverse-column logic used in decryption. It accepts a 128-bit state over a valid/ready handshake and transforms one 32-bit column per clock through a single shared column unit. It returns the result over a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the round pipeline and is bypassed by the round controller in the final round.

## Interface
- No parameters; state width is fixed at 128 bits and column width at 32 bits.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream has a state on `in_state`.
- `in_ready`  out  1  engine can accept a state.
- `in_state`  in  128  input state; column c = `[127-32c -: 32]`, byte 0 of each column in its MSBs.
- `out_valid`  out  1  `out_state` holds a completed result.
- `out_ready`  in  1  downstream accepts the result.
- `out_state`  out  128  transformed state, same layout as the input.
- `inv`  in  1  present only with `MIX_COLUMNS_INV_EN`; selects the inverse transform for the state being accepted.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, capture `in_state` into the state register, clear column counter `col` to 0, latch `inv`, and go to BUSY.
  - BUSY: each cycle, replace column `col` with `mix(column col)` and increment `col`. When `col`==3 is written, go to DONE.
  - DONE: `out_valid`=1 and `out_state` holds the result. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. There is no overlap: a new state is not accepted in the same cycle as an output handshake.
- Forward column arithmetic over GF(2^8), reduction polynomial 0x11B:
  - o0 = 2a0^3a1^a2^a3
  - o1 = a0^2a1^3a2^a3
  - o2 = a0^a1^2a2^3a3
  - o3 = 3a0^a1^a2^2a3
- Inverse column arithmetic (enabled build only): coefficient rows {0e,0b,0d,09}, rotated the same way.
- xtime(b) = {b[6:0],0} ^ (0x1B & {8{b[7]}}). All intermediates are 8 bits wide, with no carries.
- `out_state` is a direct view of the state register. It is stable while `out_valid`=1 and `out_ready`=0.
- Reset (`rst_n`=0 at an edge), from any state including mid-BUSY: return to IDLE, clear the state register to 0, `col`=0, latched `inv`=0. Any partial result is discarded.
- Reset values: `in_ready`=1, `out_valid`=0, `out_state`=0.
- `in_state` and `inv` are ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Input handshake at edge N: columns 0..3 are written at edges N+1..N+4. `out_valid` rises after edge N+4, giving a latency of 4 cycles.
- Output handshake at edge M: `in_ready` rises after M, so the next input is accepted no earlier than edge M+1.
- Peak throughput is one state per 6 cycles with `out_ready` tied high.
- The critical path is one column unit: at most 3 xtime stages plus an XOR tree.

## Configuration
- `MIX_COLUMNS_INV_EN` defined:
  - The `inv` port exists and is latched at acceptance.
  - `inv`=1 applies InvMixColumns, so one engine serves both directions.
- Undefined:
  - The `inv` port is absent and the engine is forward-only.
  - No inverse multipliers are synthesised.

## Structure
- `aes_pkg` holds the following shared items:
  - the `AES_POLY_LO` = 8'h1B constant;
  - the `xtime` and `gf_mul_const` functions;
  - the `mixcol_state_t` enum {IDLE, BUSY, DONE};
  - the `COL_W`=32 and `STATE_W`=128 constants.
- The combinational column transform is split into the sub-module `mix_column_word`:
  - ports: 32-bit in, 32-bit out, and `inv` under the macro;
  - it is instantiated once, with its input muxed by `col`.

## Test plan
- FIPS-197 forward vector: `in_state`=db135345_f20a225c_01010101_2d26314c with `out_ready`=1.
  - `out_state`=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - `out_valid` rises exactly 4 cycles after acceptance.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` with input c6c6c6c6_d4d4d4d5_00000000_ffffffff.
  - `out_state`=c6c6c6c6_d5d5d7d6_00000000_ffffffff is held stable.
  - `in_ready` stays 0.
  - `out_valid` drops after the single `out_ready` pulse.
- Reset mid-operation: assert `rst_n`=0 two cycles after acceptance.
  - Next cycle: `out_valid`=0, `out_state`=0, `in_ready`=1.
  - A following vector completes normally.
- Back-to-back: hold `in_valid`=1 with two distinct vectors and `out_ready`=1.
  - The second vector is accepted at edge M+1.
  - Both results are correct and the accepted states are 6 cycles apart.
- `MIX_COLUMNS_INV_EN` build: `inv`=1 with `in_state`=8e4da1bc_9fdc589d_01010101_4d7ebdf8.
  - `out_state`=db135345_f20a225c_01010101_2d26314c.
  - The forward vector with `inv`=0 still passes.
